// File: rtl/apb2reg_mst_if.sv
// APB3 slave bus plus register-native request/ack channel toward slv_fsm.
// Latency: n/a (signal bundle only).
// Backpressure: n/a; the "slave" modport is the bridge side, "master" the bus/FSM stub side.
interface apb2reg_mst_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  // APB side
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  // Register-native side toward slv_fsm
  logic                  mst__fsm__req_vld;
  logic [ADDR_WIDTH-1:0] mst__fsm__addr;
  logic                  mst__fsm__wr_en;
  logic                  mst__fsm__rd_en;
  logic [DATA_WIDTH-1:0] mst__fsm__wr_data;
  logic                  mst__fsm__sync_reset;
  logic                  fsm__mst__ack_vld;
  logic [DATA_WIDTH-1:0] fsm__mst__rd_data;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr,
    output mst__fsm__req_vld, mst__fsm__addr, mst__fsm__wr_en, mst__fsm__rd_en,
    output mst__fsm__wr_data, mst__fsm__sync_reset,
    input  fsm__mst__ack_vld, fsm__mst__rd_data
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr,
    input  mst__fsm__req_vld, mst__fsm__addr, mst__fsm__wr_en, mst__fsm__rd_en,
    input  mst__fsm__wr_data, mst__fsm__sync_reset,
    output fsm__mst__ack_vld, fsm__mst__rd_data
  );
endinterface

// File: rtl/apb2reg_mst.sv
// APB3 slave -> single-request register handshake bridge with ack timeout and soft-reset abort.
// Latency: setup -> REQ -> (WAIT)* -> DONE; min 1 APB wait state, pready in the cycle after ack/abort.
// Backpressure: APB stalled (pready low) until ack, timeout or soft reset; one transfer outstanding.
// Ports: clk, rstn (async active-low), soft_rst (sync level), bus (APB + mst__fsm__/fsm__mst__ channel).
module apb2reg_mst #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                soft_rst,
  apb2reg_mst_if.slave        bus
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    ABORT = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  late_q, late_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic [CW-1:0]         cnt_inc;
  logic                  tmo_hit;
  logic                  active;

  assign cnt_inc = cnt_q + CW'(1);
  // The current REQ/WAIT cycle is the TIMEOUT-th one without an ack.
  assign tmo_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    late_d    = late_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (soft_rst) begin
          // Remember a setup that arrived while blocked; its access phase
          // (psel & penable) is accepted as a late setup once soft_rst drops.
          late_d = bus.psel;
        end else if (bus.psel && (!bus.penable || late_q)) begin
          addr_d  = bus.paddr;
          wdata_d = bus.pwdata;
          wr_d    = bus.pwrite;
          late_d  = 1'b0;
          state_d = REQ;
        end else begin
          late_d = 1'b0;
        end
      end
      REQ, WAIT: begin
        if (soft_rst) begin
          state_d = ABORT;
        end else if (bus.fsm__mst__ack_vld) begin
          // Ack beats a coincident timeout.
          state_d  = DONE;
          pready_d = 1'b1;
          prdata_d = wr_q ? '0 : bus.fsm__mst__rd_data;
        end else if (tmo_hit) begin
          state_d = ABORT;
        end else begin
          if (TIMEOUT != 0) cnt_d = cnt_inc;
          state_d = WAIT;
        end
      end
      ABORT: begin
        state_d   = DONE;
        pready_d  = 1'b1;
        pslverr_d = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      late_q    <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      late_q    <= late_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Request qualifiers are only driven while a request is in flight.
  assign active                   = (state_q == REQ) || (state_q == WAIT);
  assign bus.mst__fsm__req_vld    = (state_q == REQ);
  assign bus.mst__fsm__addr       = active ? addr_q : '0;
  assign bus.mst__fsm__wr_data    = active ? wdata_q : '0;
  assign bus.mst__fsm__wr_en      = active & wr_q;
  assign bus.mst__fsm__rd_en      = active & ~wr_q;
  assign bus.mst__fsm__sync_reset = soft_rst | (state_q == ABORT);

  assign bus.pready  = pready_q;
  assign bus.prdata  = prdata_q;
  assign bus.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb2reg_mst.sv
// Self-checking bench for apb2reg_mst: scoreboard of expected APB responses plus per-cycle request checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_apb2reg_mst;

  localparam int AW  = 64;
  localparam int DW  = 32;
  localparam int TMO = 4;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic clk;
  logic rstn;
  logic soft_rst;

  rsp_t sb_q[$];
  int   tests_run;
  int   tests_failed;

  apb2reg_mst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb2reg_mst #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .soft_rst(soft_rst),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One APB transfer. ack_dly / soft_at are cycle offsets from the REQ cycle (-1 = never).
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int ack_dly, input logic [DW-1:0] rd, input int soft_at);
    int   ab;
    int   pr;
    int   last_act;
    logic err;
    logic seen;
    logic act;
    rsp_t r;

    // Reference model: abort cycle, response cycle and response content.
    ab = TMO;
    if (soft_at >= 0 && soft_at + 1 < ab) ab = soft_at + 1;
    err      = !(ack_dly >= 0 && ack_dly < ab && ack_dly != soft_at);
    pr       = err ? ab + 1 : ack_dly + 1;
    last_act = err ? ab - 1 : ack_dly;
    r.rdata  = (err || wr) ? '0 : rd;
    r.err    = err;
    sb_q.push_back(r);

    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = a;
    bus.pwdata  = wd;
    @(negedge clk);
    bus.penable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k <= pr + 2 && !seen; k++) begin
      bus.fsm__mst__ack_vld = (k == ack_dly);
      bus.fsm__mst__rd_data = (k == ack_dly) ? rd : '0;
      soft_rst              = (k == soft_at);
      #1;
      act = (k <= last_act);
      chk($sformatf("req_vld@%0d", k), bus.mst__fsm__req_vld, k == 0);
      chk($sformatf("sync_reset@%0d", k), bus.mst__fsm__sync_reset,
          (k == soft_at) || (err && k == ab));
      chk($sformatf("addr@%0d", k), bus.mst__fsm__addr, act ? a : '0);
      chk($sformatf("wr_data@%0d", k), bus.mst__fsm__wr_data, act ? wd : '0);
      chk($sformatf("wr_en@%0d", k), bus.mst__fsm__wr_en, act & wr);
      chk($sformatf("rd_en@%0d", k), bus.mst__fsm__rd_en, act & ~wr);
      chk($sformatf("pready@%0d", k), bus.pready, k == pr);
      if (bus.pready) begin
        seen = 1'b1;
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
          r = sb_q.pop_front();
          chk("prdata", bus.prdata, r.rdata);
          chk("pslverr", bus.pslverr, r.err);
        end
      end
      @(negedge clk);
    end
    chk("pready_seen", seen, 1'b1);
    if (!seen && sb_q.size() > 0) r = sb_q.pop_front();
    bus.psel              = 1'b0;
    bus.penable           = 1'b0;
    bus.fsm__mst__ack_vld = 1'b0;
    soft_rst              = 1'b0;
    @(negedge clk);
    #1;
    chk("pready_one_cycle", bus.pready, 1'b0);
    chk("idle_req_vld", bus.mst__fsm__req_vld, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run             = 0;
    tests_failed          = 0;
    rstn                  = 1'b0;
    soft_rst              = 1'b0;
    bus.psel              = 1'b0;
    bus.penable           = 1'b0;
    bus.pwrite            = 1'b0;
    bus.paddr             = '0;
    bus.pwdata            = '0;
    bus.fsm__mst__ack_vld = 1'b0;
    bus.fsm__mst__rd_data = '0;

    // Reset values, sync_reset follows soft_rst
    @(negedge clk);
    #1;
    chk("rst_pready", bus.pready, 1'b0);
    chk("rst_prdata", bus.prdata, '0);
    chk("rst_pslverr", bus.pslverr, 1'b0);
    chk("rst_req_vld", bus.mst__fsm__req_vld, 1'b0);
    chk("rst_addr", bus.mst__fsm__addr, '0);
    chk("rst_wr_en", bus.mst__fsm__wr_en, 1'b0);
    chk("rst_rd_en", bus.mst__fsm__rd_en, 1'b0);
    chk("rst_wr_data", bus.mst__fsm__wr_data, '0);
    chk("rst_sync_reset_lo", bus.mst__fsm__sync_reset, 1'b0);
    soft_rst = 1'b1;
    #1;
    chk("rst_sync_reset_hi", bus.mst__fsm__sync_reset, 1'b1);
    soft_rst = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 1: single-cycle write ack
    xfer(1'b1, 64'h10, 32'hDEADBEEF, 0, '0, -1);
    // 2: read, ack 3 cycles after REQ (also the 4th REQ/WAIT cycle with TIMEOUT=4)
    xfer(1'b0, 64'h20, '0, 3, 32'h12345678, -1);
    // 3: timeout, then a normal transfer
    xfer(1'b0, 64'h30, '0, -1, 32'hAAAA5555, -1);
    xfer(1'b1, 64'h34, 32'h00C0FFEE, 1, '0, -1);
    // 4: ack at the timeout boundary on a write, and a read with wide address
    xfer(1'b1, 64'h40, 32'h01020304, TMO - 1, '0, -1);
    xfer(1'b0, 64'hFFFF_0000_0000_0048, '0, 2, 32'hCAFEF00D, -1);
    // 5: soft reset pulses in WAIT and in REQ
    xfer(1'b0, 64'h50, '0, -1, '0, 1);
    xfer(1'b1, 64'h54, 32'h99, 3, '0, 0);

    // soft_rst in IDLE blocks the setup; late setup accepted once it drops
    soft_rst    = 1'b1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b1;
    bus.paddr   = 64'h70;
    bus.pwdata  = 32'h77;
    #1;
    chk("blk_sync_reset", bus.mst__fsm__sync_reset, 1'b1);
    @(negedge clk);
    bus.penable = 1'b1;
    #1;
    chk("blk_req_vld0", bus.mst__fsm__req_vld, 1'b0);
    @(negedge clk);
    soft_rst = 1'b0;
    #1;
    chk("blk_req_vld1", bus.mst__fsm__req_vld, 1'b0);
    @(negedge clk);
    bus.fsm__mst__ack_vld = 1'b1;
    #1;
    chk("late_req_vld", bus.mst__fsm__req_vld, 1'b1);
    chk("late_addr", bus.mst__fsm__addr, 64'h70);
    chk("late_wr_en", bus.mst__fsm__wr_en, 1'b1);
    @(negedge clk);
    bus.fsm__mst__ack_vld = 1'b0;
    #1;
    chk("late_pready", bus.pready, 1'b1);
    chk("late_pslverr", bus.pslverr, 1'b0);
    @(negedge clk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(negedge clk);

    // 6: async reset in WAIT
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = 64'h60;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    #1;
    chk("ar_rd_en_before", bus.mst__fsm__rd_en, 1'b1);
    rstn = 1'b0;
    #1;
    chk("ar_req_vld", bus.mst__fsm__req_vld, 1'b0);
    chk("ar_rd_en", bus.mst__fsm__rd_en, 1'b0);
    chk("ar_addr", bus.mst__fsm__addr, '0);
    chk("ar_pready", bus.pready, 1'b0);
    chk("ar_pslverr", bus.pslverr, 1'b0);
    chk("ar_sync_reset", bus.mst__fsm__sync_reset, 1'b0);
    @(negedge clk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("ar_no_pready", bus.pready, 1'b0);
    @(negedge clk);
    xfer(1'b0, 64'h64, '0, 1, 32'h0BADF00D, -1);

    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
